// File: rtl/regfile_sb.sv
// Multi-read-port register file with per-register pending scoreboard and hardwired x0.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRP  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_busy,
    input  logic                wrt_en,
    input  logic [AW-1:0]       oprd,
    input  logic [XLEN-1:0]     wrt_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic                rsv_ready,
    output logic [AW:0]         busy_cnt
);

    localparam int NREGS = 1 << AW;

    logic [XLEN-1:0]  r_mem [NREGS];
    logic [NREGS-1:0] r_pend;
    logic [AW:0]      r_busy_cnt;

    logic w_wr;
    logic w_rsv_acc;
    logic w_set;
    logic w_clr;

    assign w_wr = wrt_en && (oprd != '0);

    // A same-cycle write to the reserved register frees it for the new producer.
    assign rsv_ready = !rsv_en || (rsv_addr == '0) || !r_pend[rsv_addr] ||
                       (wrt_en && (oprd == rsv_addr));
    assign w_rsv_acc = rsv_en && rsv_ready && (rsv_addr != '0);

    // Write+reserve of the same pending register leaves its bit set: neither set nor clear.
    assign w_set = w_rsv_acc && !r_pend[rsv_addr];
    assign w_clr = w_wr && r_pend[oprd] && !(w_rsv_acc && (rsv_addr == oprd));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
            r_pend     <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_mem[oprd]  <= wrt_data;
                r_pend[oprd] <= 1'b0;
            end
            if (w_rsv_acc) begin
                r_pend[rsv_addr] <= 1'b1;
            end
            r_busy_cnt <= r_busy_cnt + (AW+1)'(w_set) - (AW+1)'(w_clr);
        end
    end

    assign busy_cnt = r_busy_cnt;

    for (genvar p = 0; p < NRP; p++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_rd;
        assign w_ra = rd_addr[p*AW +: AW];
        assign w_rd = (w_ra == '0) ? '0 : r_mem[w_ra];
`ifdef REGFILE_BYPASS_EN
        logic w_fwd;
        assign w_fwd = w_wr && (oprd == w_ra);
        assign rd_data[p*XLEN +: XLEN] = w_fwd ? wrt_data : w_rd;
        assign rd_busy[p] = !w_fwd && r_pend[w_ra];
`else
        assign rd_data[p*XLEN +: XLEN] = w_rd;
        assign rd_busy[p] = r_pend[w_ra];
`endif
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed, table-driven bench for regfile_sb (default parameters, two read ports).
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wrt_en;
    logic [4:0]  oprd;
    logic [31:0] wrt_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        rsv_ready;
    logic [5:0]  busy_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wrt_en   (wrt_en),
        .oprd     (oprd),
        .wrt_data (wrt_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rsv_ready(rsv_ready),
        .busy_cnt (busy_cnt)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [4:0]  ra;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  busy;
        logic        rdy;
        logic [5:0]  cnt;
    } vec_t;

    vec_t tv[17];

    function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd,
                                logic re, logic [4:0] ra, logic [4:0] a0, logic [4:0] a1,
                                logic [31:0] d0, logic [31:0] d1, logic [1:0] busy,
                                logic rdy, logic [5:0] cnt);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.busy = busy; v.rdy = rdy; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re, input logic [4:0] ra,
                         input logic [4:0] a0, input logic [4:0] a1);
        wrt_en = we; oprd = wa; wrt_data = wd;
        rsv_en = re; rsv_addr = ra;
        rd_addr = {a1, a0};
    endtask

    task automatic check_all(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                             input logic [1:0] busy, input logic rdy, input logic [5:0] cnt);
        n_vec++;
        chk({tag, " rd_data0"}, rd_data[31:0], d0);
        chk({tag, " rd_data1"}, rd_data[63:32], d1);
        chk({tag, " rd_busy"}, 32'(rd_busy), 32'(busy));
        chk({tag, " rsv_ready"}, 32'(rsv_ready), 32'(rdy));
        chk({tag, " busy_cnt"}, 32'(busy_cnt), 32'(cnt));
    endtask

    initial begin
        //          we wa  wd            re ra  a0  a1  d0      d1      busy   rdy cnt
        tv[0]  = mk(0, 0,  0,            0, 0,  6,  8,  0,      0,      2'b00, 1,  0);
        tv[1]  = mk(1, 6,  9,            0, 0,  0,  1,  0,      0,      2'b00, 1,  0);
        tv[2]  = mk(1, 8,  7,            0, 0,  6,  0,  9,      0,      2'b00, 1,  0);
        tv[3]  = mk(1, 5,  11,           0, 0,  6,  8,  9,      7,      2'b00, 1,  0);
        tv[4]  = mk(0, 0,  0,            0, 0,  5,  6,  11,     9,      2'b00, 1,  0);
        tv[5]  = mk(1, 0,  32'hDEADBEEF, 1, 0,  0,  5,  0,      11,     2'b00, 1,  0);
        tv[6]  = mk(0, 0,  0,            0, 0,  0,  0,  0,      0,      2'b00, 1,  0);
        tv[7]  = mk(0, 0,  0,            1, 3,  3,  5,  0,      11,     2'b00, 1,  0);
        tv[8]  = mk(0, 0,  0,            1, 3,  3,  6,  0,      9,      2'b01, 0,  1);
        tv[9]  = mk(0, 0,  0,            0, 0,  3,  3,  0,      0,      2'b11, 1,  1);
        tv[10] = mk(1, 3,  5,            0, 0,  6,  5,  9,      11,     2'b00, 1,  1);
        tv[11] = mk(0, 0,  0,            0, 0,  3,  5,  5,      11,     2'b00, 1,  0);
        tv[12] = mk(0, 0,  0,            1, 4,  4,  0,  0,      0,      2'b00, 1,  0);
        tv[13] = mk(1, 4,  32'h44,       1, 4,  3,  5,  5,      11,     2'b00, 1,  1);
        tv[14] = mk(0, 0,  0,            0, 0,  4,  4,  32'h44, 32'h44, 2'b11, 1,  1);
        tv[15] = mk(1, 4,  32'h45,       0, 0,  3,  5,  5,      11,     2'b00, 1,  1);
        tv[16] = mk(0, 0,  0,            0, 0,  4,  6,  32'h45, 9,      2'b00, 1,  0);

        drive(0, 0, 0, 0, 0, 6, 8);
        #2;
        check_all("reset", 0, 0, 2'b00, 1, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(tv[i].we, tv[i].wa, tv[i].wd, tv[i].re, tv[i].ra, tv[i].a0, tv[i].a1);
            #1;
            check_all($sformatf("vec%0d", i), tv[i].d0, tv[i].d1, tv[i].busy, tv[i].rdy, tv[i].cnt);
        end

        // Forwarding: x10 holds 0x22 and is pending when 0x55 is written while being read.
        @(negedge clk); drive(1, 10, 32'h22, 0, 0, 0, 0);
        @(negedge clk); drive(0, 0, 0, 1, 10, 0, 0);
        @(negedge clk); drive(1, 10, 32'h55, 0, 0, 10, 0);
        #1;
`ifdef REGFILE_BYPASS_EN
        check_all("bypass_same", 32'h55, 0, 2'b00, 1, 1);
`else
        check_all("bypass_same", 32'h22, 0, 2'b01, 1, 1);
`endif
        @(negedge clk); drive(0, 0, 0, 0, 0, 10, 10);
        #1;
        check_all("bypass_next", 32'h55, 32'h55, 2'b00, 1, 0);

        // Fill x1..x7 with data and reservations, then reset between edges.
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            drive(1, 5'(i), 32'(i * 16), 1, 5'(i), 0, 0);
        end
        @(negedge clk); drive(0, 0, 0, 1, 3, 1, 7);
        #1;
        check_all("filled", 32'h10, 32'h70, 2'b11, 0, 7);
        #1;
        rst = 1'b0;
        #1;
        check_all("async_rst", 0, 0, 2'b00, 1, 0);
        rd_addr = {5'd10, 5'd5};
        #1;
        check_all("async_rst_b", 0, 0, 2'b00, 1, 0);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 3, 4);
        #1;
        check_all("post_rst", 0, 0, 2'b00, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port integer register file with a per-register pending scoreboard, successor to the fixed 32x32 two-read/one-write register file in the rv32i core. The decode stage uses it to read operands, reserve destination registers on issue and detect RAW hazards. Writeback stores results and clears each register's pending bit. The architectural zero register is hardwired.

## Interface
- XLEN, 32, data width in bits
- AW, 5, address width; NREGS = 2**AW registers
- NRP, 2, number of read ports (1..4)

- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-low
- rd_addr  input  NRP*AW  read addresses, port p at bits [p*AW +: AW]
- rd_data  output  NRP*XLEN  read data, port p at bits [p*XLEN +: XLEN]
- rd_busy  output  NRP  per-port pending flag for rd_addr
- wrt_en  input  1  write strobe
- oprd  input  AW  write address
- wrt_data  input  XLEN  write data
- rsv_en  input  1  reserve request (issue of an instruction writing rsv_addr)
- rsv_addr  input  AW  register to mark pending
- rsv_ready  output  1  reservation accepted when high
- busy_cnt  output  AW+1  number of currently pending registers

## Operation
- State: NREGS x XLEN data array, NREGS-bit pending vector, busy_cnt counter.
- Reads are combinational: rd_data[p] = reg[rd_addr[p]]; rd_busy[p] = pending[rd_addr[p]].
- Address 0: reads return 0, rd_busy is 0, writes are ignored, reservation is always accepted with no state change.
- Write (wrt_en, oprd != 0): reg[oprd] <= wrt_data and pending[oprd] <= 0 at the clock edge. A write to a non-pending register is legal and leaves busy_cnt unchanged.
- rsv_ready = !rsv_en || rsv_addr == 0 || !pending[rsv_addr] || (wrt_en && oprd == rsv_addr). The last term means a same-cycle write to that register frees it.
- Accepted reserve (rsv_en && rsv_ready, rsv_addr != 0): pending[rsv_addr] <= 1.
- Rejected reserve: no state change. The requester holds rsv_en and rsv_addr until rsv_ready is high.
- Simultaneous write and reserve to the same register: the data is written and the pending bit ends at 1 (the new producer wins).
- busy_cnt <= busy_cnt + set - clr, where set = accepted reserve of a non-pending register and clr = write clearing a set pending bit. The counter equals popcount(pending) at all times and never wraps, because at most NREGS-1 bits can be set.

## Timing
- Reset (rst low, asynchronous): all registers 0, pending 0, busy_cnt 0. Consequently rd_data = 0, rd_busy = 0, rsv_ready = 1.
- Reset asserted mid-operation discards all pending state immediately. There is no handshake recovery.
- Writes and reservations take effect at the next rising edge. Read latency is 0 cycles from the registered state.
- rsv_ready is combinational in the same cycle as rsv_en. busy_cnt is registered and reflects the previous edge's updates.

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read forwarding. If wrt_en && oprd == rd_addr[p] && oprd != 0, then rd_data[p] = wrt_data and rd_busy[p] = 0 in the same cycle.
- REGFILE_BYPASS_EN undefined: reads return the pre-edge contents and pending bit. The writer's value is visible one cycle later.

## Test plan
- Reset then write: release rst, write 9 to x6, 7 to x8, 11 to x5 on consecutive cycles. Then read x6/x8 -> 9/7; x5 -> 11; busy_cnt = 0.
- x0 rule: write 0xDEADBEEF to x0, reserve x0, read x0 -> rd_data = 0, rd_busy = 0, rsv_ready = 1, busy_cnt = 0.
- Scoreboard: reserve x3 -> rd_busy on a port addressing x3 goes high next cycle, busy_cnt = 1. A second reserve of x3 -> rsv_ready = 0 with no change. Write 5 to x3 -> rd_busy = 0, busy_cnt = 0.
- Same-cycle write plus reserve of x4 while pending: rsv_ready = 1; next cycle reg x4 = write value, pending = 1, busy_cnt unchanged.
- Bypass: write 0x55 to x10 while reading x10.
  - With REGFILE_BYPASS_EN: rd_data = 0x55 and rd_busy = 0 that cycle.
  - Without it: the old value that cycle, 0x55 the next cycle.
- Async reset mid-run: reserve x1..x7 (busy_cnt = 7) and fill data, then pulse rst low between edges -> immediately all rd_data = 0, rd_busy = 0, busy_cnt = 0.
